// File: rtl/div_ctrl_if.sv
// Bundle between the EX-stage divide front-end and its two neighbours:
// the pipeline (op/result/stall) and the iterative divider (start/done/operands).
interface div_ctrl_if;
   logic        op_valid_i;
   logic [2:0]  funct3_i;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic        flush_i;
   logic        stall_o;
   logic        result_valid_o;
   logic [31:0] result_o;
   logic        div_start_o;
   logic [31:0] div_dividend_o;
   logic [31:0] div_divisor_o;
   logic        div_is_signed_o;
   logic [31:0] div_quotient_i;
   logic [31:0] div_remainder_i;
   logic        div_done_i;

   modport slave (
      input  op_valid_i, funct3_i, rs1_i, rs2_i, flush_i,
      input  div_quotient_i, div_remainder_i, div_done_i,
      output stall_o, result_valid_o, result_o,
      output div_start_o, div_dividend_o, div_divisor_o, div_is_signed_o
   );

   modport master (
      output op_valid_i, funct3_i, rs1_i, rs2_i, flush_i,
      output div_quotient_i, div_remainder_i, div_done_i,
      input  stall_o, result_valid_o, result_o,
      input  div_start_o, div_dividend_o, div_divisor_o, div_is_signed_o
   );
endinterface

// File: rtl/div_ctrl.sv
// RV32M divide front-end: resolves divide-by-zero, signed overflow and a one-entry
// result cache locally, otherwise launches the iterative divider and stalls EX.
//
// state  | meaning
// IDLE   | waiting for a divide op
// RESP   | result_o valid this cycle, pipeline released
// LAUNCH | div_start_o high for one cycle
// WAIT   | divider busy, waiting for div_done_i
// DRAIN  | op was flushed, divider still busy; result discarded
module div_ctrl (
   input  logic       clk_i,
   input  logic       reset_n_i,
   div_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, RESP, LAUNCH, WAIT, DRAIN} state_t;

   state_t      state_q;
   logic        result_valid_q;
   logic [31:0] result_q;
   logic        div_start_q;
   logic [31:0] dividend_q;
   logic [31:0] divisor_q;
   logic        is_signed_q;
   logic        rem_sel_q;
   logic        cache_valid_q;
   logic [31:0] cache_rs1_q;
   logic [31:0] cache_rs2_q;
   logic        cache_signed_q;
   logic [31:0] cache_quot_q;
   logic [31:0] cache_rem_q;

   logic        is_signed_in;
   logic        div_by_zero;
   logic        signed_ovf;
   logic        cache_hit;
   logic        accept;
   logic [31:0] local_quot_d;
   logic [31:0] local_rem_d;
   logic [31:0] result_sel_d;

   assign is_signed_in = ~bus.funct3_i[0];
   assign div_by_zero  = (bus.rs2_i == 32'h0);
   assign signed_ovf   = is_signed_in && (bus.rs1_i == 32'h8000_0000) && (bus.rs2_i == 32'hFFFF_FFFF);
   assign cache_hit    = cache_valid_q && (cache_rs1_q == bus.rs1_i) && (cache_rs2_q == bus.rs2_i)
                         && (cache_signed_q == is_signed_in);
   assign accept       = (state_q == IDLE) && bus.op_valid_i && bus.funct3_i[2] && !bus.flush_i;

   // Results resolvable without the divider, in priority order.
   always_comb begin
      local_quot_d = cache_quot_q;
      local_rem_d  = cache_rem_q;
      if (div_by_zero) begin
         local_quot_d = 32'hFFFF_FFFF;
         local_rem_d  = bus.rs1_i;
      end else if (signed_ovf) begin
         local_quot_d = 32'h8000_0000;
         local_rem_d  = 32'h0;
      end
      result_sel_d = bus.funct3_i[1] ? local_rem_d : local_quot_d;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q        <= IDLE;
         result_valid_q <= 1'b0;
         result_q       <= 32'h0;
         div_start_q    <= 1'b0;
         dividend_q     <= 32'h0;
         divisor_q      <= 32'h0;
         is_signed_q    <= 1'b0;
         rem_sel_q      <= 1'b0;
         cache_valid_q  <= 1'b0;
         cache_rs1_q    <= 32'h0;
         cache_rs2_q    <= 32'h0;
         cache_signed_q <= 1'b0;
         cache_quot_q   <= 32'h0;
         cache_rem_q    <= 32'h0;
      end else begin
         div_start_q    <= 1'b0;
         result_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (div_by_zero || signed_ovf || cache_hit) begin
                     result_q       <= result_sel_d;
                     result_valid_q <= 1'b1;
                     state_q        <= RESP;
                  end else begin
                     dividend_q  <= bus.rs1_i;
                     divisor_q   <= bus.rs2_i;
                     is_signed_q <= is_signed_in;
                     rem_sel_q   <= bus.funct3_i[1];
                     div_start_q <= 1'b1;
                     state_q     <= LAUNCH;
                  end
               end
            end
            LAUNCH: state_q <= bus.flush_i ? DRAIN : WAIT;
            WAIT: begin
               // A flush coinciding with done retires the divider run directly.
               if (bus.flush_i) begin
                  if (bus.div_done_i) begin
                     cache_valid_q <= 1'b0;
                     state_q       <= IDLE;
                  end else begin
                     state_q <= DRAIN;
                  end
               end else if (bus.div_done_i) begin
                  result_q       <= rem_sel_q ? bus.div_remainder_i : bus.div_quotient_i;
                  result_valid_q <= 1'b1;
                  cache_valid_q  <= 1'b1;
                  cache_rs1_q    <= dividend_q;
                  cache_rs2_q    <= divisor_q;
                  cache_signed_q <= is_signed_q;
                  cache_quot_q   <= bus.div_quotient_i;
                  cache_rem_q    <= bus.div_remainder_i;
                  state_q        <= RESP;
               end
            end
            RESP: state_q <= IDLE;
            DRAIN: begin
               if (bus.div_done_i) begin
                  cache_valid_q <= 1'b0;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.stall_o         = bus.op_valid_i && bus.funct3_i[2] && (state_q != RESP);
   assign bus.result_valid_o  = result_valid_q && !bus.flush_i;
   assign bus.result_o        = result_q;
   assign bus.div_start_o     = div_start_q;
   assign bus.div_dividend_o  = dividend_q;
   assign bus.div_divisor_o   = divisor_q;
   assign bus.div_is_signed_o = is_signed_q;

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Execute-stage front-end for the RV32M divide instructions (DIV, DIVU, REM, REMU); it sits directly upstream of the iterative `divider`. It decodes funct3 and resolves divide-by-zero and signed overflow locally. It launches the divider with a single-cycle start pulse and selects the quotient or remainder. A one-entry result cache lets a DIV/REM pair on identical operands complete without a second divider run. It stalls the pipeline until the result is ready and handles flushes and resets while the divider is busy.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk_i` in 1: clock, rising edge.
- `reset_n_i` in 1: synchronous, active-low reset.
- `op_valid_i` in 1: EX holds a valid M-extension op; held with operands stable while `stall_o`=1.
- `funct3_i` in 3: 100 DIV, 101 DIVU, 110 REM, 111 REMU; funct3[2]=0 means not a divide op and is ignored.
- `rs1_i` / `rs2_i` in 32: dividend / divisor.
- `flush_i` in 1: kill the in-flight op.
- `stall_o` out 1: hold the EX stage.
- `result_valid_o` out 1: one-cycle pulse; `result_o` is valid.
- `result_o` out 32: rd write data.
- `div_start_o` out 1: divider start, single-cycle pulse.
- `div_dividend_o` / `div_divisor_o` out 32: divider operands, registered, stable from start until done.
- `div_is_signed_o` out 1: equals ~funct3[0].
- `div_quotient_i` / `div_remainder_i` in 32: divider results, valid while `div_done_i`=1.
- `div_done_i` in 1: divider finished.

## Operation
- States: IDLE, RESP, LAUNCH, WAIT, DRAIN.
- Accept condition: IDLE & `op_valid_i` & funct3[2] & ~`flush_i`. Resolution priority on accept:
  1. Divisor == 0: quotient 0xFFFFFFFF, remainder rs1, both signed and unsigned. Go to RESP.
  2. Signed op with rs1 0x80000000 and rs2 0xFFFFFFFF: quotient 0x80000000, remainder 0. Go to RESP.
  3. Cache hit (cache valid and rs1, rs2 and signedness all match): return cached quotient/remainder. Go to RESP.
  4. Otherwise: latch operands and signedness. Go to LAUNCH.
- LAUNCH: `div_start_o`=1 for exactly this cycle, then WAIT.
- WAIT: on the first cycle with `div_done_i`=1, capture quotient and remainder into the result register and the cache (operands, signedness, valid=1). Go to RESP.
- RESP: `result_valid_o`=1 and `result_o` = quotient for DIV/DIVU, remainder for REM/REMU. Return to IDLE.
- `stall_o` = `op_valid_i` & funct3[2] & (state != RESP). It is combinational, so the accept cycle already stalls.
- Special-case results never write or invalidate the cache.
- `flush_i` has the highest priority:
  - IDLE or RESP: suppress accept and `result_valid_o`; go to IDLE.
  - LAUNCH: still issue the start pulse; go to DRAIN.
  - WAIT: go to DRAIN.
  - DRAIN: wait for `div_done_i`, discard the result, clear cache valid, go to IDLE. `stall_o` is 1 for any divide op presented during DRAIN.
- After `div_done_i` has been consumed, the state never re-enters WAIT on the same done level: LAUNCH always precedes WAIT.

## Timing
- Reset values: state IDLE, cache valid 0, `result_valid_o` 0, `div_start_o` 0, `result_o` 0, `div_dividend_o` 0, `div_divisor_o` 0, `div_is_signed_o` 0. `stall_o` follows its equation from the inputs.
- Reset in any state (including WAIT or DRAIN) returns to IDLE. The divider is reset on the same `reset_n_i` by the top level, so no drain is needed after reset.
- Special case or cache hit: accept in cycle T, `result_valid_o` in T+1. Total: 2 cycles, 1 stall cycle.
- Divider path: accept T, start T+1, divider done observed in cycle D, `result_valid_o` in D+1.
- Back-to-back ops: the next op can be accepted in the cycle after RESP.

## Test plan
- DIV -103/20: one start pulse; `result_o`=0xFFFFFFFB (-5). Then REM with the same operands: no start, `result_valid_o` 1 cycle after accept, `result_o`=0xFFFFFFFD (-3).
- DIV -10/-6 gives 1; REM -10/-6 gives 0xFFFFFFFC (-4); REM 5/-3 gives 2; DIVU 10/3 gives 3. REMU 10/3 after the DIVU is a cache hit returning 1, while DIV 10/3 after DIVU 10/3 misses (signedness differs) and starts the divider.
- DIVU 7/0 → 0xFFFFFFFF; REM 7/0 → 7; DIV 0x80000000/-1 → 0x80000000; REM 0x80000000/-1 → 0. None of these pulses `div_start_o` or changes the cache.
- Flush in WAIT of DIV 100/7: no `result_valid_o`; DRAIN until done. A following REM 100/7 misses the cache and relaunches, returning 2.
- Assert `reset_n_i`=0 for one cycle during WAIT: all outputs take their reset values next cycle. A following DIV 9/3 returns 3.
- Hold `div_done_i` high 3 cycles: exactly one `result_valid_o` pulse and one capture.
